mdu32: RTL and testbench
========================

MDU32 -- requirements
Module: mdu32

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
REQ-006 S  input  32  first operand, regfile32 S port (multiplicand / dividend).
REQ-007 T  input  32  second operand, regfile32 T port (multiplier / divisor).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when the result is written to HI/LO.
REQ-010 div_by_zero  output  1  sticky until the next accepted start; set when a DIV/DIVU had T=0.
REQ-011 HI  output  32  product[63:32] or remainder.
REQ-012 LO  output  32  product[31:0] or quotient.

Function
REQ-013 SHALL implement states IDLE, RUN, FIN; IDLE->RUN on start=1; RUN->FIN after the 32nd iteration; FIN->IDLE unconditionally.
REQ-014 SHALL latch op, S and T on the clk edge that accepts start; later operand changes have no effect.
REQ-015 SHALL ignore start while busy=1 or in FIN; no queuing.
REQ-016 busy SHALL be 1 from the cycle after acceptance through the last RUN cycle, and 0 in IDLE and FIN.
REQ-017 Signed ops SHALL convert operands to magnitudes at acceptance, iterate unsigned, and apply sign correction in FIN.
REQ-018 Multiply SHALL use 1 shift-add iteration per RUN cycle, 32 iterations, over a 64-bit accumulator.
REQ-019 Divide SHALL use 1 restoring shift-subtract iteration per RUN cycle, 32 iterations.
REQ-020 Latency SHALL be fixed: done asserts in the 34th cycle after the acceptance edge, and HI/LO update on that same edge.
REQ-021 Signed quotient SHALL truncate toward zero; remainder SHALL take the dividend's sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0; no trap.
REQ-023 MULT 0x80000000 * 0x80000000 SHALL give HI=0x40000000, LO=0.
REQ-024 DIV or DIVU with T=0 SHALL skip RUN, go IDLE->FIN on acceptance, pulse done on the next cycle, set div_by_zero=1, and leave HI/LO unchanged.
REQ-025 An accepted start SHALL clear div_by_zero.
REQ-026 HI/LO SHALL hold their value between operations and change only on the done edge.
REQ-027 If start=1 during the FIN cycle, it SHALL be ignored; a new operation is accepted from IDLE only.

Reset
REQ-028 On reset=0: state=IDLE; busy=0, done=0, div_by_zero=0, HI=0, LO=0; internal accumulators cleared.
REQ-029 Reset asserted mid-RUN SHALL abort the operation; no done pulse and no HI/LO update may follow.
REQ-030 Release of reset SHALL NOT start an operation even if start=1; acceptance requires a clk edge with reset=1.

Verification
REQ-031 MULTU S=FFFFFFFF T=FFFFFFFF -> HI=FFFFFFFE, LO=00000001, done pulses exactly 34 cycles after acceptance, busy high for 32 cycles.
REQ-032 MULT S=FFFFFFFE(-2) T=00000003 -> HI=FFFFFFFF, LO=FFFFFFFA; DIV S=FFFFFFF9(-7) T=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-033 DIVU S=00000064 T=00000000 -> done one cycle after acceptance, div_by_zero=1, HI/LO keep prior values; the next start clears div_by_zero.
REQ-034 Start MULTU 3*5; pulse start with other operands at RUN cycle 10; change S/T mid-RUN -> result HI=0, LO=0000000F, single done.
REQ-035 Start DIVU 100/7; assert reset=0 at RUN cycle 15 for 3 cycles -> HI=LO=0, busy=0, no done; a following DIVU 100/7 -> LO=0000000E, HI=00000002.
REQ-036 Drive S/T from regfile32 with R5=00000006 and R6=00000007 via S_Addr=5, T_Addr=6; MULTU -> LO=0000002A, HI=0.

Source files
------------

// File: rtl/mdu32.sv
// mdu32: iterative 32-bit multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per RUN
// cycle over a 64-bit accumulator. Signed operations work on magnitudes and
// fix up the signs in FIN. Result lands in HI/LO on the edge that leaves FIN.
module mdu32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] S,
  input  logic [31:0] T,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [31:0] a_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic [63:0] acc_d;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        s_neg;
  logic        t_neg;
  logic [31:0] s_mag;
  logic [31:0] t_mag;
  logic        div0;

  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] x);
    return neg ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] x);
    return neg ? (~x + 64'd1) : x;
  endfunction

  // Product in the upper half, multiplier bits shift out of the low end.
  function automatic logic [63:0] mul_step(input logic [63:0] acc, input logic [31:0] a);
    logic [32:0] sum;
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a} : 33'd0);
    return {sum, acc[31:1]};
  endfunction

  // Remainder in the upper half, quotient bits shift in at the low end.
  // The remainder stays below the divisor, so a non-negative difference
  // always fits in 32 bits and bit 32 is a clean borrow flag.
  function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] a);
    logic [32:0] diff;
    diff = acc[63:31] - {1'b0, a};
    if (diff[32]) return {acc[62:0], 1'b0};
    else          return {diff[31:0], acc[30:0], 1'b1};
  endfunction

  // Operand conditioning at acceptance and per-cycle step / final fix-up.
  always_comb begin
    s_neg = ~op[0] & S[31];
    t_neg = ~op[0] & T[31];
    s_mag = cond_neg32(s_neg, S);
    t_mag = cond_neg32(t_neg, T);
    div0  = op[1] & (T == 32'd0);
    acc_d = op_q[1] ? div_step(acc_q, a_q) : mul_step(acc_q, a_q);
    hi_d  = 32'd0;
    lo_d  = 32'd0;
    if (op_q[1]) begin
      hi_d = cond_neg32(rneg_q, acc_q[63:32]);
      lo_d = cond_neg32(qneg_q, acc_q[31:0]);
    end else begin
      {hi_d, lo_d} = cond_neg64(qneg_q, acc_q);
    end
  end

  // Control FSM with registered busy/done/div_by_zero and HI/LO results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            cnt_q  <= 5'd0;
            dz_q   <= div0;
            qneg_q <= s_neg ^ t_neg;
            rneg_q <= s_neg;
            if (op[1]) begin
              acc_q <= {32'd0, s_mag};
              a_q   <= t_mag;
            end else begin
              acc_q <= {32'd0, t_mag};
              a_q   <= s_mag;
            end
            if (div0) begin
              state_q <= FIN;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (!dz_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mdu32.sv
// tb_mdu32: directed vector table plus hand sequences for mdu32.
module tb_mdu32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] S;
  logic [31:0] T;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  mdu32 dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .S(S), .T(T),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] rf[32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Accept on edge E0; lat = number of edges after E0 until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t,
                        output int lat, output int bcnt, output logic dz_acc,
                        output logic hold_ok, output logic after_done);
    logic [31:0] ph, pl;
    @(negedge clk);
    ph = HI; pl = LO;
    start = 1'b1; op = o; S = s; T = t;
    @(posedge clk); #1;
    start = 1'b0; S = $urandom; T = $urandom; op = 2'($urandom);
    dz_acc = div_by_zero;
    bcnt = busy ? 1 : 0;
    lat = -1; hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (busy) bcnt++;
      if (HI !== ph || LO !== pl) hold_ok = 1'b0;
    end
    @(posedge clk); #1;
    after_done = done;
  endtask

  initial begin
    int lat, bcnt, dn, busy34;
    logic dz_acc, hold_ok, after_done;
    logic [31:0] ph, pl;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
    vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[9]  = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[11] = '{2'b11, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000};
    vecs[12] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    // Reset held with start=1; release must not start anything.
    reset = 1'b0; start = 1'b1; op = 2'b01; S = 32'd3; T = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(div_by_zero), 64'd0);
    chk("rst_hi",   64'(HI), 64'd0);
    chk("rst_lo",   64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_busy", 64'(busy), 64'd0);
    #2 start = 1'b0;
    @(posedge clk); #1;
    chk("rel_busy2", 64'(busy), 64'd0);
    chk("rel_done2", 64'(done), 64'd0);

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].s, vecs[i].t, lat, bcnt, dz_acc, hold_ok, after_done);
      chk($sformatf("v%0d_hi", i),   64'(HI), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i),   64'(LO), 64'(vecs[i].lo));
      chk($sformatf("v%0d_lat", i),  64'(lat), 64'd33);
      chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'd32);
      chk($sformatf("v%0d_dz", i),   64'(dz_acc), 64'd0);
      chk($sformatf("v%0d_hold", i), 64'(hold_ok), 64'd1);
      chk($sformatf("v%0d_pulse", i), 64'(after_done), 64'd0);
    end

    // Results hold in IDLE.
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold_hi", 64'(HI), 64'h1);
    chk("idle_hold_lo", 64'(LO), 64'h23456780);

    // DIVU by zero: fast done, sticky flag, HI/LO untouched.
    ph = HI; pl = LO;
    run_op(2'b11, 32'h64, 32'h0, lat, bcnt, dz_acc, hold_ok, after_done);
    chk("dz_lat",  64'(lat), 64'd1);
    chk("dz_busy", 64'(bcnt), 64'd0);
    chk("dz_flag", 64'(dz_acc), 64'd1);
    chk("dz_hi",   64'(HI), 64'(ph));
    chk("dz_lo",   64'(LO), 64'(pl));
    repeat (3) @(posedge clk);
    #1;
    chk("dz_sticky", 64'(div_by_zero), 64'd1);
    run_op(2'b01, 32'd3, 32'd5, lat, bcnt, dz_acc, hold_ok, after_done);
    chk("dz_clear", 64'(dz_acc), 64'd0);
    chk("dz_next_lo", 64'(LO), 64'hF);
    // Signed DIV by zero also flags.
    run_op(2'b10, 32'hFFFFFFF9, 32'h0, lat, bcnt, dz_acc, hold_ok, after_done);
    chk("sdz_flag", 64'(div_by_zero), 64'd1);
    chk("sdz_lo",   64'(LO), 64'hF);

    // Start mid-RUN and in FIN are ignored; operand changes have no effect.
    @(negedge clk);
    start = 1'b1; op = 2'b01; S = 32'd3; T = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; S = 32'hDEADBEEF; T = 32'h12345678;
    dn = 0; lat = -1; busy34 = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (done) begin dn++; if (lat < 0) lat = k; end
      if (k == 34) busy34 = busy ? 1 : 0;
      if (k == 9)  begin start = 1'b1; op = 2'b11; S = 32'd100; T = 32'd7; end
      if (k == 10) begin start = 1'b0; S = 32'h55555555; T = 32'hAAAAAAAA; end
      if (k == 32) begin start = 1'b1; op = 2'b01; S = 32'd2; T = 32'd2; end
      if (k == 33) start = 1'b0;
    end
    chk("mid_hi",    64'(HI), 64'd0);
    chk("mid_lo",    64'(LO), 64'hF);
    chk("mid_ndone", 64'(dn), 64'd1);
    chk("mid_lat",   64'(lat), 64'd33);
    chk("fin_ign",   64'(busy34), 64'd0);

    // Reset mid-RUN aborts; then a clean DIVU.
    @(negedge clk);
    start = 1'b1; op = 2'b11; S = 32'd100; T = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi",   64'(HI), 64'd0);
    chk("abort_lo",   64'(LO), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_ndone", 64'(dn), 64'd0);
    chk("abort_busy2", 64'(busy), 64'd0);
    chk("abort_lo2",   64'(LO), 64'd0);
    run_op(2'b11, 32'd100, 32'd7, lat, bcnt, dz_acc, hold_ok, after_done);
    chk("post_hi",  64'(HI), 64'd2);
    chk("post_lo",  64'(LO), 64'hE);
    chk("post_lat", 64'(lat), 64'd33);

    // Operands sourced from a register file model.
    for (int r = 0; r < 32; r++) rf[r] = 32'(r * 3 + 1);
    rf[5] = 32'h6; rf[6] = 32'h7;
    begin
      logic [4:0] s_addr, t_addr;
      s_addr = 5'd5; t_addr = 5'd6;
      run_op(2'b01, rf[s_addr], rf[t_addr], lat, bcnt, dz_acc, hold_ok, after_done);
    end
    chk("rf_hi", 64'(HI), 64'd0);
    chk("rf_lo", 64'(LO), 64'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
